// File: rtl/inv_flow_cntr_pkg.sv
// inv_flow_cntr_pkg: shared constants, FSM encoding and word/byte slice helpers
// for the AES-128 decryption flow controller.
//   BLOCK_W    - block width (128)
//   WORD_W     - word / column width (32)
//   NUM_RND    - number of AES rounds (10)
//   LAST_CYCLE - terminal word counter value (4*NUM_RND)
//   state_t    - IDLE / RUN / DONE
//   get_word   - word1..word4 of a block, word1 in the top bits
//   get_byte   - row0..row3 of a word, row0 in the top byte
package inv_flow_cntr_pkg;

    localparam int         BLOCK_W    = 128;
    localparam int         WORD_W     = 32;
    localparam int         NUM_RND    = 10;
    localparam logic [5:0] LAST_CYCLE = 6'(4 * NUM_RND);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // idx 0..3 selects word1..word4
    function automatic logic [WORD_W-1:0] get_word(input logic [BLOCK_W-1:0] blk,
                                                   input logic [1:0] idx);
        return idx == 2'd0 ? blk[127:96] :
               idx == 2'd1 ? blk[95:64]  :
               idx == 2'd2 ? blk[63:32]  : blk[31:0];
    endfunction

    // row 0..3 selects byte row0..row3
    function automatic logic [7:0] get_byte(input logic [WORD_W-1:0] wd,
                                            input logic [1:0] row);
        return row == 2'd0 ? wd[31:24] :
               row == 2'd1 ? wd[23:16] :
               row == 2'd2 ? wd[15:8]  : wd[7:0];
    endfunction

endpackage

// File: rtl/inv_flow_cntr_shift_sel.sv
// inv_shift_row_sel: InvShiftRows column selection, purely combinational.
// Ports:
//   word0..word3 - the four state columns (word1..word4 of the block)
//   col          - output column index j (0..3)
//   word_out     - column j after InvShiftRows: row r taken from column (j-r) mod 4
module inv_shift_row_sel
    import inv_flow_cntr_pkg::*;
(
    input  logic [WORD_W-1:0] word0,
    input  logic [WORD_W-1:0] word1,
    input  logic [WORD_W-1:0] word2,
    input  logic [WORD_W-1:0] word3,
    input  logic [1:0]        col,
    output logic [WORD_W-1:0] word_out
);

    logic [WORD_W-1:0] words [4];

    assign words = '{word0, word1, word2, word3};

    // 2-bit subtraction wraps, giving the mod-4 source column directly
    always_comb begin
        word_out = '0;
        for (int r = 0; r < 4; r++)
            word_out[31 - 8*r -: 8] = get_byte(words[col - 2'(r)], 2'(r));
    end

endmodule

// File: rtl/inv_flow_cntr.sv
// inv_flow_cntr: AES-128 decryption flow controller. Loads a ciphertext block
// with the initial AddRoundKey, streams 40 InvShiftRows-selected words through
// an external inverse-round datapath with X/Y ping-pong banks, and presents
// the plaintext with a one-cycle valid pulse.
// Ports:
//   clk, reset          - clock, asynchronous active-low reset
//   block_data_in(_vld) - ciphertext block and its valid
//   last_rnd_key        - round key 10, packed like the block
//   key_available       - key schedule ready
//   sbox_available      - inverse S-box ready
//   word_in_comb(_vld)  - datapath result for the current word; vld gates progress
//   data_accept         - ready to take a block (IDLE only)
//   data_out(_vld)      - plaintext and its one-cycle valid
//   word_out_comb(_vld) - selected word sent to the datapath
//   rnd_key_gen         - key-schedule enable while running
//   key_rnd_idx         - round key index for the datapath (9..0)
//   inv_mix_column_off  - bypass InvMixColumns in the final round
module inv_flow_cntr
    import inv_flow_cntr_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [BLOCK_W-1:0]  block_data_in,
    input  logic                block_data_in_vld,
    input  logic [BLOCK_W-1:0]  last_rnd_key,
    input  logic                key_available,
    input  logic                sbox_available,
    input  logic [WORD_W-1:0]   word_in_comb,
    input  logic                word_in_comb_vld,
    output logic                data_accept,
    output logic [BLOCK_W-1:0]  data_out,
    output logic                data_out_vld,
    output logic [WORD_W-1:0]   word_out_comb,
    output logic                word_out_comb_vld,
    output logic                rnd_key_gen,
    output logic [3:0]          key_rnd_idx,
    output logic                inv_mix_column_off
);

    state_t              state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [WORD_W-1:0]   x_q [4];
    logic [WORD_W-1:0]   x_d [4];
    logic [WORD_W-1:0]   y_q [4];
    logic [WORD_W-1:0]   y_d [4];
    logic [BLOCK_W-1:0]  data_out_q, data_out_d;
    logic                data_out_vld_q, data_out_vld_d;
    logic [5:0]          idx;
    logic [1:0]          col;
    logic [3:0]          rnd;
    logic                run;
    logic [WORD_W-1:0]   sel_word;

    // cnt runs 1..40 in RUN, so cnt-1 splits into round (upper) and column (lower)
    assign idx = cnt_q - 6'd1;
    assign col = idx[1:0];
    assign rnd = idx[5:2];
    assign run = state_q == ST_RUN;

    // even rounds read X and write Y, odd rounds the reverse
    inv_shift_row_sel u_sel (
        .word0    (rnd[0] ? y_q[0] : x_q[0]),
        .word1    (rnd[0] ? y_q[1] : x_q[1]),
        .word2    (rnd[0] ? y_q[2] : x_q[2]),
        .word3    (rnd[0] ? y_q[3] : x_q[3]),
        .col      (col),
        .word_out (sel_word)
    );

    assign data_accept        = state_q == ST_IDLE && key_available && sbox_available;
    assign word_out_comb      = run ? sel_word : '0;
    assign word_out_comb_vld  = run;
    assign rnd_key_gen        = run;
    assign key_rnd_idx        = run ? 4'(NUM_RND - 1) - rnd : 4'd0;
    assign inv_mix_column_off = run && rnd == 4'(NUM_RND - 1);
    assign data_out           = data_out_q;
    assign data_out_vld       = data_out_vld_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        x_d            = x_q;
        y_d            = y_q;
        data_out_d     = data_out_q;
        data_out_vld_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (block_data_in_vld && data_accept) begin
                    for (int i = 0; i < 4; i++)
                        x_d[i] = get_word(block_data_in, 2'(i)) ^ get_word(last_rnd_key, 2'(i));
                    cnt_d   = 6'd1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (word_in_comb_vld) begin
                    if (rnd[0])
                        x_d[col] = word_in_comb;
                    else
                        y_d[col] = word_in_comb;
                    // the final round writes X; word4 comes straight from the datapath
                    if (cnt_q == LAST_CYCLE) begin
                        data_out_d     = {x_q[0], x_q[1], x_q[2], word_in_comb};
                        data_out_vld_d = 1'b1;
                        cnt_d          = 6'd0;
                        state_d        = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            x_q            <= '{default: '0};
            y_q            <= '{default: '0};
            data_out_q     <= '0;
            data_out_vld_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            x_q            <= x_d;
            y_q            <= y_d;
            data_out_q     <= data_out_d;
            data_out_vld_q <= data_out_vld_d;
        end
    end

endmodule

// File: tb/tb_inv_flow_cntr.sv
// tb_inv_flow_cntr: directed bench with a loopback / AES inverse-round datapath model.
module tb_inv_flow_cntr;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] block_data_in;
    logic         block_data_in_vld;
    logic [127:0] last_rnd_key;
    logic         key_available;
    logic         sbox_available;
    logic [31:0]  word_in_comb;
    logic         word_in_comb_vld;
    logic         data_accept;
    logic [127:0] data_out;
    logic         data_out_vld;
    logic [31:0]  word_out_comb;
    logic         word_out_comb_vld;
    logic         rnd_key_gen;
    logic [3:0]   key_rnd_idx;
    logic         inv_mix_column_off;

    inv_flow_cntr dut (
        .clk                (clk),
        .reset              (reset),
        .block_data_in      (block_data_in),
        .block_data_in_vld  (block_data_in_vld),
        .last_rnd_key       (last_rnd_key),
        .key_available      (key_available),
        .sbox_available     (sbox_available),
        .word_in_comb       (word_in_comb),
        .word_in_comb_vld   (word_in_comb_vld),
        .data_accept        (data_accept),
        .data_out           (data_out),
        .data_out_vld       (data_out_vld),
        .word_out_comb      (word_out_comb),
        .word_out_comb_vld  (word_out_comb_vld),
        .rnd_key_gen        (rnd_key_gen),
        .key_rnd_idx        (key_rnd_idx),
        .inv_mix_column_off (inv_mix_column_off)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] AES_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] AES_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] AES_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] LB_IN   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] LB_OUT  = 128'h0009020b040d060f08010a030c050e07;

    typedef struct {
        logic         loopback;
        logic [127:0] ct;
        logic [127:0] pt;
        int           stall_at;
        int           stall_len;
    } vec_t;

    int           n_cmp = 0;
    int           n_err = 0;
    int           hs = 0;
    logic         loop_mode = 1'b1;
    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [127:0] rk    [16];
    logic [127:0] rkv;
    logic [31:0]  kw;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [31:0] inv_round(input logic [31:0] wd, input logic [31:0] k,
                                              input logic mix_off);
        logic [31:0] t;
        logic [7:0]  a0, a1, a2, a3;
        t = {isbox[wd[31:24]], isbox[wd[23:16]], isbox[wd[15:8]], isbox[wd[7:0]]} ^ k;
        a0 = t[31:24]; a1 = t[23:16]; a2 = t[15:8]; a3 = t[7:0];
        if (mix_off) return t;
        return {gm(a0, 8'd14) ^ gm(a1, 8'd11) ^ gm(a2, 8'd13) ^ gm(a3, 8'd9),
                gm(a0, 8'd9)  ^ gm(a1, 8'd14) ^ gm(a2, 8'd11) ^ gm(a3, 8'd13),
                gm(a0, 8'd13) ^ gm(a1, 8'd9)  ^ gm(a2, 8'd14) ^ gm(a3, 8'd11),
                gm(a0, 8'd11) ^ gm(a1, 8'd13) ^ gm(a2, 8'd9)  ^ gm(a3, 8'd14)};
    endfunction

    // external datapath model; the column index comes from the bench's own handshake count
    always_comb begin
        rkv = rk[key_rnd_idx];
        kw  = rkv[127 - 32*(hs % 4) -: 32];
        word_in_comb = loop_mode ? word_out_comb : inv_round(word_out_comb, kw, inv_mix_column_off);
    end

    always @(posedge clk)
        if (block_data_in_vld && data_accept) hs <= 0;
        else if (word_out_comb_vld && word_in_comb_vld) hs <= hs + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic build_tables();
        logic [7:0]  inv, s, rc;
        logic [31:0] w [44];
        logic [31:0] t;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[a]  = s;
            isbox[s] = 8'(a);
        end
        for (int i = 0; i < 4; i++) w[i] = AES_KEY[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk[r] = r < 11 ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    task automatic wait_accept(input string tag);
        @(negedge clk);
        for (int i = 0; i < 50 && !data_accept; i++) @(negedge clk);
        check({tag, "/accept_ready"}, data_accept, 1);
    endtask

    task automatic run_block(input vec_t v, input string tag);
        int          lat, stalled;
        logic        done;
        logic [31:0] held;
        loop_mode        = v.loopback;
        last_rnd_key     = v.loopback ? 128'h0 : rk[10];
        block_data_in    = v.ct;
        word_in_comb_vld = 1'b1;
        held             = '0;
        wait_accept(tag);
        block_data_in_vld = 1'b1;
        @(posedge clk);
        #1 block_data_in_vld = 1'b0;
        lat = 0; stalled = 0; done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (data_out_vld) begin
                done = 1'b1;
            end else begin
                check({tag, "/run_strobes"}, {word_out_comb_vld, rnd_key_gen, data_accept}, 3'b110);
                check({tag, "/key_rnd_idx"}, key_rnd_idx, 9 - hs / 4);
                check({tag, "/imc_off"}, inv_mix_column_off, hs >= 36);
                if (hs == v.stall_at - 1 && stalled < v.stall_len) begin
                    if (stalled == 0) held = word_out_comb;
                    else check({tag, "/stall_hold"}, word_out_comb, held);
                    word_in_comb_vld = 1'b0;
                    stalled++;
                end else begin
                    word_in_comb_vld = 1'b1;
                end
                @(posedge clk);
                lat++;
            end
        end
        word_in_comb_vld = 1'b1;
        check({tag, "/done_seen"}, done, 1);
        check({tag, "/latency"}, lat, 40 + v.stall_len);
        check({tag, "/data_out"}, data_out, v.pt);
        @(negedge clk);
        check({tag, "/vld_one_cycle"}, data_out_vld, 0);
        check({tag, "/data_out_hold"}, data_out, v.pt);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "/data_out"}, data_out, 0);
        check({tag, "/strobes"}, {data_out_vld, word_out_comb_vld, rnd_key_gen, inv_mix_column_off}, 4'b0);
        check({tag, "/word_out_comb"}, word_out_comb, 0);
        check({tag, "/key_rnd_idx"}, key_rnd_idx, 0);
    endtask

    initial begin
        vec_t vecs [5];
        int   lat, seen, vld_cnt;
        int   seen_lat [2];

        reset = 1'b0;
        block_data_in = '0;
        block_data_in_vld = 1'b0;
        last_rnd_key = '0;
        key_available = 1'b1;
        sbox_available = 1'b1;
        word_in_comb_vld = 1'b1;
        build_tables();

        vecs[0] = '{1'b1, LB_IN,  LB_OUT, 0,  0};
        vecs[1] = '{1'b0, AES_CT, AES_PT, 0,  0};
        vecs[2] = '{1'b0, AES_CT, AES_PT, 10, 3};
        vecs[3] = '{1'b1, LB_IN,  LB_OUT, 40, 1};
        vecs[4] = '{1'b0, AES_CT, AES_PT, 1,  2};

        // reset state
        repeat (3) @(negedge clk);
        check_idle_outputs("in_reset");
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("after_reset");
        check("after_reset/data_accept", data_accept, 1);

        for (int i = 0; i < 5; i++) run_block(vecs[i], $sformatf("vec%0d", i));

        // not ready: request is ignored
        sbox_available = 1'b0;
        loop_mode = 1'b1;
        block_data_in = LB_IN;
        @(negedge clk);
        check("no_sbox/data_accept", data_accept, 0);
        block_data_in_vld = 1'b1;
        @(negedge clk);
        block_data_in_vld = 1'b0;
        repeat (3) @(negedge clk);
        check("no_sbox/stays_idle", {word_out_comb_vld, data_out_vld, data_accept}, 3'b000);
        key_available = 1'b0;
        sbox_available = 1'b1;
        @(negedge clk);
        check("no_key/data_accept", data_accept, 0);
        key_available = 1'b1;
        run_block(vecs[0], "after_sbox");

        // reset at cnt=20
        loop_mode = 1'b0;
        last_rnd_key = rk[10];
        block_data_in = AES_CT;
        word_in_comb_vld = 1'b1;
        wait_accept("midrst");
        block_data_in_vld = 1'b1;
        @(posedge clk);
        #1 block_data_in_vld = 1'b0;
        for (int i = 0; i < 100 && hs != 19; i++) @(negedge clk);
        check("midrst/reached_cnt20", {word_out_comb_vld, 8'(hs)}, {1'b1, 8'd19});
        #2 reset = 1'b0;
        #1 check_idle_outputs("midrst");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        vld_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (data_out_vld) vld_cnt++;
        end
        check("midrst/no_vld", vld_cnt, 0);
        run_block(vecs[1], "after_midrst");

        // back-to-back with vld held high
        loop_mode = 1'b0;
        last_rnd_key = rk[10];
        block_data_in = AES_CT;
        word_in_comb_vld = 1'b1;
        wait_accept("b2b");
        block_data_in_vld = 1'b1;
        @(posedge clk);
        lat = 0; seen = 0;
        seen_lat[0] = -1; seen_lat[1] = -1;
        for (int c = 0; c < 300 && seen < 2; c++) begin
            @(negedge clk);
            if (data_out_vld) begin
                seen_lat[seen] = lat;
                check($sformatf("b2b/data_out%0d", seen), data_out, AES_PT);
                seen++;
            end
            if (seen < 2) begin
                @(posedge clk);
                lat++;
            end
        end
        block_data_in_vld = 1'b0;
        check("b2b/first_latency", seen_lat[0], 40);
        check("b2b/second_latency", seen_lat[1], 82);
        @(negedge clk);
        check("b2b/vld_one_cycle", data_out_vld, 0);
        repeat (3) @(negedge clk);
        check("b2b/no_third", word_out_comb_vld, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
